// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory.
// Optional misaligned-access faults are enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        illegal;
    logic        oob;
    logic        misalign;
    logic        req_fault;
    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [31:0] rd_shift;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classify the incoming request as faulting or not
    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_store;
            default:                illegal = 1'b1;
        endcase
        oob = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
`ifdef MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_fault = illegal | oob | misalign;
    end

    assign b_sh = {addr_q[1:0], 3'b000};
    assign h_sh = {addr_q[1], 4'b0000};

    // Lane selection, extension and store merge for the captured access
    always_comb begin
        rd_shift = mem_read_data >> b_sh;
        lane_b   = rd_shift[7:0];
        lane_h   = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'h0, lane_b};
            3'b101:  load_val = {16'h0, lane_h};
            default: load_val = mem_read_data;
        endcase
        if (funct3_q[0]) begin
            merged = (mem_read_data & ~(32'h0000_FFFF << h_sh))
                   | ({16'h0, word_q[15:0]} << h_sh);
        end else begin
            merged = (mem_read_data & ~(32'h0000_00FF << b_sh))
                   | ({24'h0, word_q[7:0]} << b_sh);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD:     state_d = RESP;
            RMW_READ: state_d = WRITE;
            WRITE:    state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, fill on memory reads
    always_comb begin
        funct3_d = funct3_q;
        addr_d   = addr_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    word_d   = req_wdata;
                    rdata_d  = 32'h0;
                    fault_d  = req_fault;
                end
            end
            LOAD:     rdata_d = load_val;
            RMW_READ: word_d  = merged;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Outputs decoded from state; all forced low while reset is held
    always_comb begin
        req_ready  = !reset && (state_q == IDLE);
        MemRead    = !reset && ((state_q == LOAD) || (state_q == RMW_READ));
        MemWrite   = !reset && (state_q == WRITE);
        resp_valid = !reset && (state_q == RESP);
        mem_address    = (MemRead || MemWrite) ? {2'b00, addr_q[31:2]} : 32'h0;
        mem_write_data = MemWrite ? word_q : 32'h0;
        resp_rdata     = resp_valid ? rdata_q : 32'h0;
        resp_fault     = resp_valid && fault_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model plus directed literals.
// A negedge process checks every output every cycle against the model.
module tb_load_store_unit;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    bit          load_mem = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_store(req_store),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h8877_66F0;
        if (i == 2) return 32'h1122_3344;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // data memory attached to the DUT
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
        end else if (MemWrite && mem_address < MW) begin
            mem[mem_address[9:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = (MemRead && mem_address < MW)
                         ? mem[mem_address[9:0]] : 32'h0;

    // ---------------- transaction-level reference model ----------------
    bit          busy = 1'b0;
    int          k = 0;
    int          lat = 0;
    int          m_idx = 0;
    bit          m_fault = 1'b0;
    bit          m_load = 1'b0;
    bit          m_sw = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_new = 32'h0;

    task automatic predict(input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, b, h;
        int sh, hs, off;
        bit mis;
        m_idx = int'(a >> 2);
        off = int'(a % 4);
        w = (m_idx < MW) ? ref_mem[m_idx] : 32'h0;
        sh = 8 * off;
        hs = (off >= 2) ? 16 : 0;
        b = (w >> sh) & 32'hFF;
        h = (w >> hs) & 32'hFFFF;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = ((f3 == 1 || f3 == 5) && (off % 2 != 0))
            || (f3 == 2 && off != 0);
`endif
        m_fault = (f3 == 3) || (f3 >= 6) || (st && f3 >= 4)
                || (m_idx >= MW) || mis;
        m_load = !st;
        m_sw = st && (f3 == 2);
        m_addr = a;
        m_rdata = 32'h0;
        m_new = 32'h0;
        if (m_fault) begin
            lat = 1;
        end else if (!st) begin
            lat = 2;
            case (f3)
                3'd0: m_rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd1: m_rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                3'd4: m_rdata = b;
                3'd5: m_rdata = h;
                default: m_rdata = w;
            endcase
        end else if (f3 == 2) begin
            lat = 2;
            m_new = wd;
        end else begin
            lat = 3;
            if (f3 == 0) m_new = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else m_new = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        end
    endtask

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
        end
        if (reset) begin
            busy = 1'b0;
            k = 0;
        end else if (!busy) begin
            if (req_valid) begin
                predict(req_store, req_funct3, req_addr, req_wdata);
                busy = 1'b1;
                k = 1;
            end
        end else begin
            if (!m_fault && !m_load && k == (m_sw ? 1 : 2)) ref_mem[m_idx] = m_new;
            if (k >= lat && resp_ready) busy = 1'b0;
            else k++;
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic e_rr, e_rv, e_mr, e_mw, e_f;
        logic [31:0] e_rd, e_ma, e_wd;
        e_rr = !reset && !busy;
        e_rv = !reset && busy && (k >= lat);
        e_mr = !reset && busy && !m_fault && !m_sw && (k == 1);
        e_mw = !reset && busy && !m_fault && !m_load && (k == (m_sw ? 1 : 2));
        e_ma = (e_mr || e_mw) ? (m_addr >> 2) : 32'h0;
        e_wd = e_mw ? m_new : 32'h0;
        e_rd = e_rv ? m_rdata : 32'h0;
        e_f = e_rv && m_fault;
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("resp_fault", 32'(resp_fault), 32'(e_f));
        chk("resp_rdata", resp_rdata, e_rd);
        chk("MemRead", 32'(MemRead), 32'(e_mr));
        chk("MemWrite", 32'(MemWrite), 32'(e_mw));
        chk("mem_address", mem_address, e_ma);
        chk("mem_write_data", mem_write_data, e_wd);
    end

    // directed transaction with literal expectations; starts just after a posedge
    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_rd, input bit exp_f, input int exp_lat);
        int cyc;
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) break;
        end
        chk("dir_latency", 32'(cyc), 32'(exp_lat));
        chk("dir_rdata", resp_rdata, exp_rd);
        chk("dir_fault", 32'(resp_fault), 32'(exp_f));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        int sel;
        int bad_words;
        reset = 1'b1;
        load_mem = 1'b1;
        @(posedge clk);
        #1;
        load_mem = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        txn(1'b0, 3'b000, 32'h14, 32'h0, 0, 32'hFFFF_FFF0, 1'b0, 2);
        txn(1'b0, 3'b101, 32'h16, 32'h0, 0, 32'h0000_8877, 1'b0, 2);
        txn(1'b0, 3'b001, 32'h16, 32'h0, 4, 32'hFFFF_8877, 1'b0, 2);
        txn(1'b1, 3'b000, 32'h09, 32'h0000_00AB, 0, 32'h0, 1'b0, 3);
        chk("sb_merge_word", mem[2], 32'h1122_AB44);
        txn(1'b0, 3'b010, 32'h08, 32'h0, 0, 32'h1122_AB44, 1'b0, 2);
        txn(1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 1);
        txn(1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1);
        txn(1'b1, 3'b100, 32'h4, 32'h0, 0, 32'h0, 1'b1, 1);
        txn(1'b0, 3'b100, 32'h0FFF, 32'h0, 0, 32'h0000_00FF & (init_word(1023) >> 24), 1'b0, 2);
`ifdef MISALIGN_TRAP_EN
        txn(1'b0, 3'b010, 32'h02, 32'h0, 0, 32'h0, 1'b1, 1);
`else
        txn(1'b0, 3'b010, 32'h02, 32'h0, 0, init_word(0), 1'b0, 2);
`endif

        // reset during the read phase of an SH
        req_valid = 1'b1;
        req_store = 1'b1;
        req_funct3 = 3'b001;
        req_addr = 32'h0A;
        req_wdata = 32'h0000_5566;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_address", mem_address, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        chk("rst_no_write", mem[2], 32'h1122_AB44);
        @(posedge clk);
        #1;

        // randomized traffic, including resets and range boundaries
        repeat (4000) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 99) < 2);
            req_valid = 1'($urandom_range(0, 1));
            req_store = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) req_addr = $urandom;
            else if (sel == 1) req_addr = 32'hFF8 + 32'($urandom_range(0, 15));
            else req_addr = 32'($urandom_range(0, 255));
            req_wdata = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bad_words = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        chk("final_memory", 32'(bad_words), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
